systolic_mmu: RTL and testbench

- 2x2 output-stationary systolic matrix-multiply core. It sits directly downstream of the operand-load controller.
- Accepts the two loaded 2x2 int8 operand matrices A and B on a start pulse and computes C = A x B.
- Holds the four C elements stable for the controller's output mux and raises a sticky done flag.
- Exactly one multiply in flight at a time.

---
 rtl/tpu_pkg.sv | 29 ++
 rtl/systolic_pe.sv | 52 +++++
 rtl/systolic_mmu.sv | 168 ++++++++++++++++
 tb/tb_systolic_mmu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the tensor datapath: default widths, the
// matrix-multiply sequencer states, sequencing step counts and the
// row-major element packing helper used for the flat operand/result buses.
package tpu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;

  // Array geometry: 2x2, elements packed as row*2+col with element 0 in LSBs.
  localparam int ARR_DIM  = 2;
  localparam int NUM_ELEM = ARR_DIM * ARR_DIM;

  // Step counts for the skewed feed and the trailing drain.
  localparam int FEED_STEPS  = 3;
  localparam int DRAIN_STEPS = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mmu_state_t;

  // Flat element index of (row, col).
  function automatic int elem_idx(input int row, input int col);
    return row * ARR_DIM + col;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary processing element: forwards A right and B down
// through one register stage and accumulates the signed product of its
// current inputs. Arithmetic wraps modulo 2^ACC_W.
module systolic_pe
  import tpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [DATA_W-1:0]   a_reg;
  logic signed [DATA_W-1:0]   b_reg;
  logic signed [ACC_W-1:0]    acc_reg;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  // Full-width signed product, sign-extended (or wrapped) to the accumulator.
  assign prod     = a_in * b_in;
  assign prod_ext = ACC_W'(prod);

  // Forwarding registers and accumulator; clear wins over accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else if (clear) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else if (en) begin
      a_reg   <= a_in;
      b_reg   <= b_in;
      acc_reg <= acc_reg + prod_ext;
    end
  end

  assign a_out = a_reg;
  assign b_out = b_reg;
  assign acc   = acc_reg;

endmodule

// File: rtl/systolic_mmu.sv
// 2x2 output-stationary systolic matrix multiply, C = A x B on int8 operands.
// Operands are latched on an accepted start, skewed into the PE grid over
// FEED_STEPS steps, drained, then copied into the held c_flat result with a
// sticky done flag. Start sampled at edge E0 gives done/c_flat after E0+5.
// Optional build macro SYSTOLIC_MMU_RELU_EN clamps negative results to zero
// on the copy into c_flat (accumulators are untouched).
module systolic_mmu
  import tpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DATA_W-1:0]   a_flat,
  input  logic [4*DATA_W-1:0]   b_flat,
  output logic                  busy,
  output logic                  done,
  output logic [4*ACC_W-1:0]    c_flat
);

  mmu_state_t state_reg, state_next;
  logic [2:0] step_reg, step_next;
  logic       accept, pe_clear, pe_en, copy_c;

  logic signed [DATA_W-1:0] a_op_reg [NUM_ELEM];
  logic signed [DATA_W-1:0] b_op_reg [NUM_ELEM];
  logic signed [ACC_W-1:0]  c_reg    [NUM_ELEM];
  logic signed [ACC_W-1:0]  c_next   [NUM_ELEM];
  logic signed [ACC_W-1:0]  acc_w    [NUM_ELEM];

  // a_chain[row][col] is the A input of PE(row,col); column ARR_DIM is the
  // forward out of the last column. b_chain is the same idea going down.
  logic signed [DATA_W-1:0] a_chain [ARR_DIM][ARR_DIM+1];
  logic signed [DATA_W-1:0] b_chain [ARR_DIM+1][ARR_DIM];
  logic                     unused_edge;

  // Sequencer state and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
    end
  end

  // Next state and per-cycle controls. DRAIN covers the final skewed step
  // into PE(1,1) plus the cycle whose closing edge copies the result out.
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    accept     = 1'b0;
    pe_clear   = 1'b0;
    pe_en      = 1'b0;
    copy_c     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        accept = start;
      end
      FEED: begin
        busy      = 1'b1;
        pe_en     = 1'b1;
        step_next = step_reg + 3'd1;
        if (step_reg == 3'(FEED_STEPS - 1)) state_next = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        pe_en     = 1'b1;
        step_next = step_reg + 3'd1;
        if (step_reg == 3'(FEED_STEPS + DRAIN_STEPS)) begin
          state_next = DONE;
          copy_c     = 1'b1;
        end
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      state_next = FEED;
      step_next  = '0;
      pe_clear   = 1'b1;
    end
  end

  // Operand latch on accept, result copy on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        a_op_reg[i] <= '0;
        b_op_reg[i] <= '0;
        c_reg[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (accept) begin
          a_op_reg[i] <= a_flat[i*DATA_W +: DATA_W];
          b_op_reg[i] <= b_flat[i*DATA_W +: DATA_W];
        end
        if (copy_c) c_reg[i] <= c_next[i];
      end
    end
  end

  genvar gi, gj;

  // Skewed edge feed: row gi gets A[gi][k], column gi gets B[k][gi], with
  // k = step - gi; out-of-range slots inject zero.
  generate
    for (gi = 0; gi < ARR_DIM; gi++) begin : g_feed
      logic [2:0] k_sel;
      logic       k_ok;
      logic [1:0] a_idx, b_idx;
      assign k_sel = step_reg - 3'(gi);
      assign k_ok  = (step_reg >= 3'(gi)) && (k_sel < 3'(ARR_DIM));
      assign a_idx = {1'(gi), k_sel[0]};
      assign b_idx = {k_sel[0], 1'(gi)};
      assign a_chain[gi][0] = k_ok ? a_op_reg[a_idx] : '0;
      assign b_chain[0][gi] = k_ok ? b_op_reg[b_idx] : '0;
    end
  endgenerate

  // 2x2 PE grid.
  generate
    for (gi = 0; gi < ARR_DIM; gi++) begin : g_row
      for (gj = 0; gj < ARR_DIM; gj++) begin : g_col
        systolic_pe #(
          .DATA_W (DATA_W),
          .ACC_W  (ACC_W)
        ) u_pe (
          .clk   (clk),
          .rst_n (rst_n),
          .clear (pe_clear),
          .en    (pe_en),
          .a_in  (a_chain[gi][gj]),
          .b_in  (b_chain[gi][gj]),
          .a_out (a_chain[gi][gj+1]),
          .b_out (b_chain[gi+1][gj]),
          .acc   (acc_w[elem_idx(gi, gj)])
        );
      end
    end
  endgenerate

  // Forwards leaving the array edge have no consumer.
  assign unused_edge = ^{a_chain[0][ARR_DIM], a_chain[1][ARR_DIM],
                         b_chain[ARR_DIM][0], b_chain[ARR_DIM][1]};

  // Result shaping and flat packing.
  generate
    for (gi = 0; gi < NUM_ELEM; gi++) begin : g_out
`ifdef SYSTOLIC_MMU_RELU_EN
      assign c_next[gi] = acc_w[gi][ACC_W-1] ? '0 : acc_w[gi];
`else
      assign c_next[gi] = acc_w[gi];
`endif
      assign c_flat[gi*ACC_W +: ACC_W] = c_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_mmu.sv
// Self-checking bench for systolic_mmu: expected C matrices are computed by
// a behavioural model when a multiply is started, queued, and compared when
// done rises. Directed checks cover reset, latency, busy window, start
// while busy, back-to-back starts and asynchronous reset mid-run.
module tb_systolic_mmu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a_flat;
  logic [31:0] b_flat;
  logic        busy;
  logic        done;
  logic [63:0] c_flat;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [63:0] sb_q[$];
  logic        done_q;

  systolic_mmu #(
    .DATA_W (8),
    .ACC_W  (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .busy   (busy),
    .done   (done),
    .c_flat (c_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pack four signed element values (row-major) into a flat int8 bus.
  function automatic logic [31:0] pack_m(input int e0, input int e1, input int e2, input int e3);
    logic [31:0] m;
    int t;
    t = e0; m[7:0]   = t[7:0];
    t = e1; m[15:8]  = t[15:8] == 8'h0 ? t[7:0] : t[7:0];
    t = e2; m[23:16] = t[7:0];
    t = e3; m[31:24] = t[7:0];
    return m;
  endfunction

  // Reference C = A x B, wrapped to 16 bits, optionally clamped at zero.
  function automatic logic [63:0] model_c(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] c;
    logic [15:0] w;
    int          s;
    c = '0;
    for (int r = 0; r < 2; r++) begin
      for (int cc = 0; cc < 2; cc++) begin
        s = 0;
        for (int k = 0; k < 2; k++)
          s += int'($signed(a[(r*2+k)*8 +: 8])) * int'($signed(b[(k*2+cc)*8 +: 8]));
        w = s[15:0];
`ifdef SYSTOLIC_MMU_RELU_EN
        if (w[15]) w = '0;
`endif
        c[(r*2+cc)*16 +: 16] = w;
      end
    end
    return c;
  endfunction

  // Scoreboard monitor: pop and compare on every rising done.
  always @(posedge clk) begin
    logic [63:0] exp_c;
    #2;
    if (rst_n && done && !done_q) begin
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_c = sb_q.pop_front();
        check("c_flat", c_flat, exp_c);
        $display("[TB] result c_flat=%h expected=%h", c_flat, exp_c);
      end
    end
    done_q = done;
  end

  // Wait (bounded) for done; returns edges counted from first_n.
  task automatic wait_done(input int first_n, input string name, output int edges);
    edges = 0;
    for (int n = first_n; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = n;
        break;
      end
      check({name, "_busy"}, 64'(busy), 64'd1);
    end
  endtask

  // One complete multiply with a single-cycle start pulse.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input string name);
    int edges;
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    sb_q.push_back(model_c(a, b));
    @(posedge clk); #1;
    start  = 1'b0;
    a_flat = ~a;
    b_flat = ~b;
    wait_done(1, name, edges);
    check({name, "_latency"}, 64'(edges), 64'd5);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int          edges;
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] exp1;

    done_q = 1'b0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_flat = '0;
    b_flat = '0;
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_c", c_flat, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_single(pack_m(1, 0, 0, 1), pack_m(5, 6, 7, 8), "identity");
    run_single(pack_m(1, 2, 3, 4), pack_m(-1, 2, 3, -4), "signed");
    run_single(pack_m(-128, -128, -128, -128), pack_m(-128, -128, -128, -128), "wrap");

    // Start pulse while busy must be ignored.
    a_flat = pack_m(1, 1, 1, 1);
    b_flat = pack_m(2, 2, 2, 2);
    start  = 1'b1;
    sb_q.push_back(model_c(a_flat, b_flat));
    @(posedge clk); #1;
    start  = 1'b0;
    @(posedge clk); #1;
    a_flat = pack_m(9, -3, 7, 5);
    b_flat = pack_m(4, 4, -6, 1);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_done(3, "ignore", edges);
    check("ignore_latency", 64'(edges), 64'd5);
    repeat (8) @(posedge clk);
    #1;
    check("ignore_done_held", 64'(done), 64'd1);
    check("ignore_busy_idle", 64'(busy), 64'd0);
    check("ignore_c_held", c_flat, 64'h0004_0004_0004_0004);

    // Back-to-back with start held high.
    a1 = pack_m(1, 2, 3, 4);
    b1 = pack_m(5, 6, 7, 8);
    a2 = pack_m(-1, 0, 0, -1);
    b2 = pack_m(3, -2, 1, 4);
    exp1 = model_c(a1, b1);
    a_flat = a1;
    b_flat = b1;
    start  = 1'b1;
    sb_q.push_back(exp1);
    sb_q.push_back(model_c(a2, b2));
    @(posedge clk); #1;
    a_flat = a2;
    b_flat = b2;
    wait_done(1, "b2b1", edges);
    check("b2b1_latency", 64'(edges), 64'd5);
    check("b2b1_c", c_flat, exp1);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_pulse", 64'(done), 64'd0);
    check("b2b_busy_restart", 64'(busy), 64'd1);
    check("b2b_c_hold", c_flat, exp1);
    wait_done(1, "b2b2", edges);
    check("b2b2_latency", 64'(edges), 64'd5);

    // Asynchronous reset during FEED step 1.
    a_flat = pack_m(2, 3, 4, 5);
    b_flat = pack_m(1, 1, 1, 1);
    start  = 1'b1;
    sb_q.push_back(model_c(a_flat, b_flat));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_c", c_flat, 64'd0);
    sb_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_single(pack_m(2, 3, 4, 5), pack_m(1, 1, 1, 1), "after_rst");

    repeat (3) @(posedge clk);
    #3;
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
